// File: rtl/alu_pkg.sv
// Shared opcode encodings, legality check and scheduler state type for the
// ALU scheduler slice.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_MOV = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_NOT, OP_XOR, OP_SHL, OP_MOV: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the favoured requester and
// moves to the loser whenever a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       gidx
);

  logic ptr;

  always_comb begin
    gidx  = (valid == 2'b11) ? ptr : (valid[1] & ~valid[0]);
    grant = 2'b00;
    if (|valid) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~gidx;
  end

endmodule

// File: rtl/alu_sched.sv
// Scheduler/sequencer for a shared combinational ALU; multi-bit SHL is built
// from repeated single-bit passes. ALU_SCHED_PERF_EN adds saturating counters.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = 5
`ifdef ALU_SCHED_PERF_EN
  ,
  parameter int CNTW = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][3:0]     req_op,
  input  logic [1:0][W-1:0]   req_a,
  input  logic [1:0][W-1:0]   req_b,
  input  logic [1:0][SHW-1:0] req_shamt,
  output logic [3:0]          alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic [W-1:0]        alu_result,
  input  logic                alu_carry,
  input  logic                alu_overflow,
  input  logic                alu_equal,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [W-1:0]        rsp_result,
  output logic                rsp_carry,
  output logic                rsp_overflow,
  output logic                rsp_equal,
  output logic                rsp_err
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [CNTW-1:0]     perf_grant0,
  output logic [CNTW-1:0]     perf_grant1,
  output logic [CNTW-1:0]     perf_busy
`endif
);

  sched_state_t   state;
  logic [SHW-1:0] cnt;
  logic           ovf_acc;
  logic [1:0]     grant;
  logic           gidx;
  logic           accept;
  logic           is_shl;
  logic           last_pass;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant),
    .gidx   (gidx)
  );

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign is_shl    = (alu_op == OP_SHL);
  assign last_pass = (cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ovf_acc      <= 1'b0;
      alu_op       <= OP_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_equal    <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id  <= gidx;
            cnt     <= req_shamt[gidx];
            ovf_acc <= 1'b0;
            alu_a   <= req_a[gidx];
            alu_b   <= req_b[gidx];
            if (op_legal(req_op[gidx])) begin
              alu_op  <= req_op[gidx];
              rsp_err <= 1'b0;
              state   <= EXEC;
            end else begin
              // Illegal ops never reach the ALU; answer next cycle with err.
              rsp_result   <= '0;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_equal    <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end
          end
        end

        EXEC: begin
          // equal always comes from the first pass, where alu_b is the request's b.
          rsp_equal <= alu_equal;
          if (is_shl && cnt == '0) begin
            rsp_result   <= alu_a;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            alu_op       <= OP_NOP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (!is_shl || last_pass) begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            cnt          <= is_shl ? cnt - SHW'(1) : cnt;
            alu_op       <= OP_NOP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            alu_a   <= alu_result;
            cnt     <= cnt - SHW'(1);
            ovf_acc <= alu_overflow;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          cnt <= cnt - SHW'(1);
          if (last_pass) begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= ovf_acc | alu_overflow;
            alu_op       <= OP_NOP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            alu_a   <= alu_result;
            ovf_acc <= ovf_acc | alu_overflow;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_busy   <= '0;
    end else begin
      if (accept && !gidx && !(&perf_grant0)) perf_grant0 <= perf_grant0 + CNTW'(1);
      if (accept &&  gidx && !(&perf_grant1)) perf_grant1 <= perf_grant1 + CNTW'(1);
      if ((state == EXEC || state == SHIFT) && !(&perf_busy))
        perf_busy <= perf_busy + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: models the external ALU, runs a directed vector table,
// arbitration/backpressure/reset sequences and randomized closed-form checks.
module tb_alu_sched;
  import alu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][4:0]  req_shamt;
  logic [3:0]       alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_equal;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_equal;
  logic             rsp_err;

  int checks   = 0;
  int failures = 0;
  int c, n, seen;

  alu_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_shamt    (req_shamt),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_equal    (alu_equal),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_equal    (rsp_equal),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: SHL is a single-bit pass; SUB carry means no borrow.
  logic [32:0] ext;
  always_comb begin
    ext          = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_equal    = (alu_a == alu_b);
    case (alu_op)
      OP_ADD: begin
        ext          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = ext[31:0];
        alu_carry    = ext[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (ext[31] != alu_a[31]);
      end
      OP_SUB: begin
        ext          = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = ext[31:0];
        alu_carry    = ~ext[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (ext[31] != alu_a[31]);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_NOT: alu_result = ~alu_a;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_SHL: begin
        alu_result   = {alu_a[30:0], 1'b0};
        alu_carry    = alu_a[31];
        alu_overflow = alu_a[31] ^ alu_a[30];
      end
      OP_MOV: alu_result = alu_a;
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        id;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        e;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Closed-form expectations: a whole n-bit shift at once, signed range tests.
  function automatic vec_t ref_model(input vec_t v);
    vec_t        r;
    longint      sa, sb, s;
    logic [63:0] u, top, mask;
    int          k;
    r     = v;
    r.res = '0; r.c = 1'b0; r.v = 1'b0; r.err = 1'b0;
    r.e   = (v.a == v.b);
    r.lat = 2;
    sa    = $signed(v.a);
    sb    = $signed(v.b);
    case (v.op)
      OP_NOP: r.res = '0;
      OP_ADD: begin
        u = {32'd0, v.a} + {32'd0, v.b};
        r.res = u[31:0]; r.c = u[32];
        s = sa + sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        r.res = v.a - v.b; r.c = (v.a >= v.b);
        s = sa - sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_AND: r.res = v.a & v.b;
      OP_OR:  r.res = v.a | v.b;
      OP_NOT: r.res = ~v.a;
      OP_XOR: r.res = v.a ^ v.b;
      OP_MOV: r.res = v.a;
      OP_SHL: begin
        k = int'(v.sh);
        if (k == 0) r.res = v.a;
        else begin
          r.res = v.a << k;
          r.c   = ((v.a >> (32 - k)) & 32'd1) != 0;
          top   = {32'd0, v.a} >> (31 - k);
          mask  = (64'd1 << (k + 1)) - 64'd1;
          r.v   = !(top == 64'd0 || top == mask);
          r.lat = 1 + k;
        end
      end
      default: begin r.e = 1'b0; r.err = 1'b1; r.lat = 1; end
    endcase
    return r;
  endfunction

  task automatic do_req(input vec_t v, input int hold, input string tag);
    int k;
    @(negedge clk);
    req_op[v.id] = v.op; req_a[v.id] = v.a; req_b[v.id] = v.b; req_shamt[v.id] = v.sh;
    req_valid[v.id] = 1'b1;
    #1;
    k = 0;
    while (!req_ready[v.id] && k < 20) begin @(negedge clk); #1; k++; end
    check({tag, "_accept"}, req_ready[v.id], 1'b1);
    if (!req_ready[v.id]) begin req_valid = 2'b00; return; end
    @(posedge clk); #1;
    req_valid = 2'b00;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k == 1) begin
        check({tag, "_aluop"}, alu_op, v.err ? OP_NOP : v.op);
        if (!v.err) check({tag, "_alua"}, alu_a, v.a);
      end
    end while (!rsp_valid && k < 60);
    check({tag, "_latency"}, k, v.lat);
    check({tag, "_result"}, rsp_result, v.res);
    check({tag, "_flags"}, {rsp_carry, rsp_overflow, rsp_equal, rsp_err}, {v.c, v.v, v.e, v.err});
    check({tag, "_id"}, rsp_id, v.id);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold"}, {rsp_valid, rsp_result, req_ready}, {1'b1, v.res, 2'b00});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv, ev;
    tbl[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[1]  = '{OP_SUB, 32'd5,        32'd5,        5'd0,  1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[2]  = '{OP_SHL, 32'h80000001, 32'h00000000, 5'd3,  1'b0, 32'h00000008, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    tbl[3]  = '{4'b0011, 32'd1,       32'd1,        5'd0,  1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{OP_SHL, 32'h12345678, 32'h12345678, 5'd0,  1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[5]  = '{OP_SHL, 32'h40000000, 32'h00000000, 5'd1,  1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[6]  = '{OP_SHL, 32'hFFFFFFFF, 32'h00000000, 5'd31, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 32};
    tbl[7]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[8]  = '{OP_NOT, 32'h00000000, 32'h00000001, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[9]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[10] = '{OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd0,  1'b0, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[11] = '{OP_MOV, 32'h00000011, 32'h00000011, 5'd0,  1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[12] = '{4'b1111, 32'h5,       32'h6,        5'd7,  1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[13] = '{OP_SUB, 32'h80000000, 32'h00000001, 5'd0,  1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[14] = '{OP_OR,  32'h0000000F, 32'h000000F0, 5'd0,  1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[15] = '{OP_NOP, 32'd3,        32'd3,        5'd0,  1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 2};

    rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
    req_shamt = '0; rsp_ready = 1'b0;
    #12;
    check("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_equal, rsp_err}, 64'd0);
    check("reset_alu", {alu_op, alu_a, alu_b}, 68'd0);
    check("reset_ready", req_ready, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    // Both requesters streaming MOVs: grants alternate starting from 0.
    @(negedge clk);
    req_op[0] = OP_MOV; req_a[0] = 32'h11; req_b[0] = '0; req_shamt[0] = '0;
    req_op[1] = OP_MOV; req_a[1] = 32'h22; req_b[1] = '0; req_shamt[1] = '0;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1 check("rr_first_grant", req_ready, 2'b01);
    n = 0; c = 0;
    while (n < 4 && c < 100) begin
      @(negedge clk); c++;
      if (rsp_valid) begin
        check("rr_id", rsp_id, n % 2);
        check("rr_result", rsp_result, (n % 2) ? 32'h22 : 32'h11);
        n++;
        if (n == 4) req_valid = 2'b00;
      end
    end
    check("rr_count", n, 4);
    @(negedge clk); rsp_ready = 1'b0;

    foreach (tbl[i]) do_req(tbl[i], i % 3, $sformatf("vec%0d", i));

    // Backpressure: response held three cycles, a pending requester waits.
    @(negedge clk);
    req_op[0] = OP_ADD; req_a[0] = 32'd3; req_b[0] = 32'd4; req_shamt[0] = '0;
    req_valid = 2'b01;
    #1 check("bp_accept0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_op[1] = OP_MOV; req_a[1] = 32'h33; req_b[1] = '0; req_shamt[1] = '0;
    req_valid = 2'b10;
    c = 0;
    do begin @(negedge clk); c++; end while (!rsp_valid && c < 20);
    check("bp_latency", c, 2);
    repeat (3) begin
      check("bp_hold", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd7});
      check("bp_no_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_ready_during_hs", req_ready, 2'b00);
    @(negedge clk); rsp_ready = 1'b0;
    #1 check("bp_resume", {rsp_valid, req_ready}, {1'b0, 2'b10});
    @(posedge clk); #1 req_valid = 2'b00;
    c = 0;
    do begin @(negedge clk); c++; end while (!rsp_valid && c < 20);
    check("bp2_latency", c, 2);
    check("bp2_rsp", {rsp_id, rsp_result}, {1'b1, 32'h33});
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;

    // Randomized traffic against the closed-form model.
    for (int i = 0; i < 100; i++) begin
      rv.op  = 4'($urandom_range(0, 15));
      rv.a   = $urandom;
      rv.b   = ($urandom_range(0, 3) == 0) ? rv.a : $urandom;
      rv.sh  = 5'($urandom_range(0, 31));
      rv.id  = 1'($urandom_range(0, 1));
      ev     = ref_model(rv);
      do_req(ev, $urandom_range(0, 2), $sformatf("rnd%0d_op%0h", i, rv.op));
    end

    // Reset in the middle of a 20-pass shift: dropped, nothing replayed.
    @(negedge clk);
    req_op[0] = OP_SHL; req_a[0] = 32'h1; req_b[0] = '0; req_shamt[0] = 5'd20;
    req_valid = 2'b01;
    #1 check("rst_accept", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (5) @(negedge clk);
    check("rst_midshift_busy", alu_op, OP_SHL);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_equal, rsp_err}, 64'd0);
    check("rst_async_alu", {alu_op, alu_a, alu_b}, 68'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || alu_op != OP_NOP) seen++;
    end
    check("rst_no_replay", seen, 0);
    req_valid = 2'b11;
    #1 check("rst_idle_ptr0", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
